// File: rtl/block_sync_rx.sv
// 64b/66b sync-header block lock for one lane: hunts for header alignment by
// requesting gearbox bit slips, then qualifies forwarded blocks with block lock.
module block_sync_rx #(
  parameter int HEAD_W     = 2,
  parameter int DATA_W     = 64,
  parameter int SH_WIN     = 64,
  parameter int SH_BAD_MAX = 16,
  parameter int SLIP_WAIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              signal_ok_i,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              slip_v_o,
  output logic              lock_v_o,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int SH_CW   = $clog2(SH_WIN + 1);
  localparam int BAD_CW  = $clog2(SH_BAD_MAX + 1);
  localparam int WAIT_CW = $clog2(SLIP_WAIT + 1);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_TEST = 2'd1;
  localparam logic [1:0] ST_SLIP = 2'd2;

  logic [1:0]         r_state,   w_state_nx;
  logic [SH_CW-1:0]   r_sh_cnt,  w_sh_cnt_nx,  w_sh_inc;
  logic [BAD_CW-1:0]  r_bad_cnt, w_bad_cnt_nx, w_bad_inc, w_bad_add;
  logic [WAIT_CW-1:0] r_wait_cnt, w_wait_cnt_nx, w_wait_inc;
  logic               r_lock, w_lock_nx;
  logic               r_slip, w_slip_nx;
  logic               r_valid;
  logic [HEAD_W-1:0]  r_head;
  logic [DATA_W-1:0]  r_data;
  logic               w_sh_ok;

  assign w_sh_ok    = head_i[1] ^ head_i[0];
  assign w_sh_inc   = (r_sh_cnt == SH_CW'(SH_WIN)) ? r_sh_cnt : r_sh_cnt + SH_CW'(1);
  assign w_bad_inc  = (r_bad_cnt == BAD_CW'(SH_BAD_MAX)) ? r_bad_cnt : r_bad_cnt + BAD_CW'(1);
  assign w_bad_add  = w_sh_ok ? r_bad_cnt : w_bad_inc;
  assign w_wait_inc = (r_wait_cnt == WAIT_CW'(SLIP_WAIT)) ? r_wait_cnt : r_wait_cnt + WAIT_CW'(1);

  // Lock FSM next-state; loss of signal overrides everything, including a due slip.
  always_comb begin
    w_state_nx    = r_state;
    w_sh_cnt_nx   = r_sh_cnt;
    w_bad_cnt_nx  = r_bad_cnt;
    w_wait_cnt_nx = r_wait_cnt;
    w_lock_nx     = r_lock;
    w_slip_nx     = 1'b0;
    if (!signal_ok_i) begin
      w_state_nx    = ST_INIT;
      w_sh_cnt_nx   = {SH_CW{1'b0}};
      w_bad_cnt_nx  = {BAD_CW{1'b0}};
      w_wait_cnt_nx = {WAIT_CW{1'b0}};
      w_lock_nx     = 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_state_nx   = ST_TEST;
          w_sh_cnt_nx  = {SH_CW{1'b0}};
          w_bad_cnt_nx = {BAD_CW{1'b0}};
          w_lock_nx    = 1'b0;
        end
        ST_TEST: begin
          if (valid_i) begin
            if (!w_sh_ok && (!r_lock || (w_bad_inc == BAD_CW'(SH_BAD_MAX)))) begin
              w_state_nx    = ST_SLIP;
              w_lock_nx     = 1'b0;
              w_slip_nx     = 1'b1;
              w_sh_cnt_nx   = {SH_CW{1'b0}};
              w_bad_cnt_nx  = {BAD_CW{1'b0}};
              w_wait_cnt_nx = {WAIT_CW{1'b0}};
            end else if (w_sh_inc == SH_CW'(SH_WIN)) begin
              if (w_bad_add == {BAD_CW{1'b0}}) begin
                w_lock_nx = 1'b1;
              end else begin
                w_lock_nx = r_lock;
              end
              w_sh_cnt_nx  = {SH_CW{1'b0}};
              w_bad_cnt_nx = {BAD_CW{1'b0}};
            end else begin
              w_sh_cnt_nx  = w_sh_inc;
              w_bad_cnt_nx = w_bad_add;
            end
          end else begin
            w_state_nx = r_state;
          end
        end
        ST_SLIP: begin
          // Headers are not judged while the gearbox settles after a slip.
          if (valid_i) begin
            if (w_wait_inc == WAIT_CW'(SLIP_WAIT)) begin
              w_state_nx    = ST_TEST;
              w_wait_cnt_nx = {WAIT_CW{1'b0}};
              w_sh_cnt_nx   = {SH_CW{1'b0}};
              w_bad_cnt_nx  = {BAD_CW{1'b0}};
            end else begin
              w_wait_cnt_nx = w_wait_inc;
            end
          end else begin
            w_state_nx = r_state;
          end
        end
        default: begin
          w_state_nx    = ST_INIT;
          w_sh_cnt_nx   = {SH_CW{1'b0}};
          w_bad_cnt_nx  = {BAD_CW{1'b0}};
          w_wait_cnt_nx = {WAIT_CW{1'b0}};
          w_lock_nx     = 1'b0;
        end
      endcase
    end
  end

  // State, counters, lock/slip flags and the one-stage forwarding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_sh_cnt   <= {SH_CW{1'b0}};
      r_bad_cnt  <= {BAD_CW{1'b0}};
      r_wait_cnt <= {WAIT_CW{1'b0}};
      r_lock     <= 1'b0;
      r_slip     <= 1'b0;
      r_valid    <= 1'b0;
      r_head     <= {HEAD_W{1'b0}};
      r_data     <= {DATA_W{1'b0}};
    end else begin
      r_state    <= w_state_nx;
      r_sh_cnt   <= w_sh_cnt_nx;
      r_bad_cnt  <= w_bad_cnt_nx;
      r_wait_cnt <= w_wait_cnt_nx;
      r_lock     <= w_lock_nx;
      r_slip     <= w_slip_nx;
      r_valid    <= valid_i & r_lock;
      if (valid_i) begin
        r_head <= head_i;
        r_data <= data_i;
      end else begin
        r_head <= r_head;
        r_data <= r_data;
      end
    end
  end

  assign slip_v_o = r_slip;
  assign lock_v_o = r_lock;
  assign valid_o  = r_valid;
  assign head_o   = r_head;
  assign data_o   = r_data;

endmodule

// File: tb/tb_block_sync_rx.sv
// Randomized directed bench for block_sync_rx against a cycle-level behavioural
// model of the block-lock rules.
module tb_block_sync_rx;
  localparam int WIN    = 64;
  localparam int BADMAX = 16;
  localparam int SWAIT  = 4;

  logic        clk = 1'b0;
  logic        reset, sok, vin;
  logic [1:0]  hin;
  logic [63:0] din;
  logic        slip, lock, vout;
  logic [1:0]  hout;
  logic [63:0] dout;

  int n_vec  = 0;
  int n_miss = 0;
  int n_slip = 0;

  // behavioural model: phase 0 = waiting for signal, 1 = judging headers, 2 = settling
  int          m_phase, m_cnt, m_bad, m_settle;
  logic        m_lock, m_slip, m_vo;
  logic [1:0]  m_ho;
  logic [63:0] m_do;

  always #5 clk = ~clk;

  block_sync_rx #(
    .HEAD_W(2), .DATA_W(64), .SH_WIN(WIN), .SH_BAD_MAX(BADMAX), .SLIP_WAIT(SWAIT)
  ) dut (
    .clk(clk), .reset(reset), .signal_ok_i(sok), .valid_i(vin), .head_i(hin), .data_i(din),
    .slip_v_o(slip), .lock_v_o(lock), .valid_o(vout), .head_o(hout), .data_o(dout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_bad = 0; m_settle = 0;
    m_lock = 1'b0; m_slip = 1'b0; m_vo = 1'b0; m_ho = 2'b00; m_do = 64'h0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] h, input logic [63:0] d, input logic s);
    bit good;
    m_vo = v & m_lock;
    if (v) begin
      m_ho = h;
      m_do = d;
    end
    m_slip = 1'b0;
    if (!s) begin
      m_phase = 0; m_lock = 1'b0; m_cnt = 0; m_bad = 0; m_settle = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_cnt = 0; m_bad = 0;
    end else if (v && m_phase == 2) begin
      m_settle++;
      if (m_settle == SWAIT) begin
        m_phase = 1; m_settle = 0; m_cnt = 0; m_bad = 0;
      end
    end else if (v && m_phase == 1) begin
      good = (h == 2'b01) || (h == 2'b10);
      m_cnt++;
      if (!good) m_bad++;
      if (!good && (!m_lock || m_bad == BADMAX)) begin
        m_lock = 1'b0; m_slip = 1'b1; m_phase = 2; m_settle = 0; m_cnt = 0; m_bad = 0;
      end else if (m_cnt == WIN) begin
        if (m_bad == 0) m_lock = 1'b1;
        m_cnt = 0; m_bad = 0;
      end
    end
  endtask

  task automatic check_all();
    if (slip === 1'b1) n_slip++;
    chk("slip_v_o", 64'(slip), 64'(m_slip));
    chk("lock_v_o", 64'(lock), 64'(m_lock));
    chk("valid_o",  64'(vout), 64'(m_vo));
    chk("head_o",   64'(hout), 64'(m_ho));
    chk("data_o",   dout, m_do);
  endtask

  task automatic step(input logic v, input logic [1:0] h);
    vin = v;
    hin = h;
    din = {$urandom, $urandom};
    @(posedge clk);
    if (reset) model_reset();
    else model_step(v, h, din, sok);
    #1;
    check_all();
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic good_run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, good_hdr());
  endtask

  task automatic bad_window(input int k);
    bit [63:0] flags;
    int placed, nb, idx;
    flags = 64'h0;
    placed = 0;
    while (placed < k) begin
      idx = $urandom_range(0, WIN - 1);
      if (!flags[idx]) begin
        flags[idx] = 1'b1;
        placed++;
      end
    end
    nb = 0;
    for (int i = 0; i < WIN; i++) begin
      if (flags[i]) begin
        nb++;
        step(1'b1, bad_hdr());
        if (nb == BADMAX) begin
          chk("s3_lock_drop", 64'(lock), 64'd0);
          chk("s3_slip_pulse", 64'(slip), 64'd1);
        end
      end else begin
        step(1'b1, good_hdr());
      end
    end
  endtask

  task automatic sync_reset_seq();
    reset = 1'b1;
    step(1'b0, 2'b00);
    reset = 1'b0;
    step(1'b0, 2'b00);
  endtask

  initial begin
    reset = 1'b1; sok = 1'b0; vin = 1'b0; hin = 2'b00; din = 64'h0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    sok = 1'b1;
    step(1'b0, 2'b00);

    // 1: clean acquisition
    n_slip = 0;
    good_run(WIN - 1);
    chk("s1_pre_lock", 64'(lock), 64'd0);
    good_run(1);
    chk("s1_lock", 64'(lock), 64'd1);
    chk("s1_no_slip", 64'(n_slip), 64'd0);

    // 2: one bad header while hunting
    sync_reset_seq();
    n_slip = 0;
    good_run(9);
    step(1'b1, 2'b11);
    chk("s2_slip", 64'(slip), 64'd1);
    for (int i = 0; i < SWAIT; i++) step(1'b1, 2'($urandom_range(0, 3)));
    good_run(WIN - 1);
    chk("s2_pre_lock", 64'(lock), 64'd0);
    good_run(1);
    chk("s2_lock", 64'(lock), 64'd1);
    chk("s2_one_slip", 64'(n_slip), 64'd1);

    // 3: 15 bad holds lock, 16 bad drops it
    n_slip = 0;
    bad_window(BADMAX - 1);
    chk("s3_held", 64'(lock), 64'd1);
    chk("s3_no_slip", 64'(n_slip), 64'd0);
    bad_window(BADMAX);
    chk("s3_slip_count", 64'(n_slip), 64'd1);
    good_run(70);
    chk("s3_relock", 64'(lock), 64'd1);

    // 4: gappy valid while locked
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), good_hdr());
    chk("s4_held", 64'(lock), 64'd1);

    // 5: signal loss while locked, with a slip due, and during slip settling
    sok = 1'b0;
    step(1'b1, good_hdr());
    chk("s5_lock_lost", 64'(lock), 64'd0);
    sok = 1'b1;
    step(1'b0, 2'b00);
    good_run(5);
    n_slip = 0;
    sok = 1'b0;
    step(1'b1, 2'b00);
    chk("s5_slip_suppressed", 64'(n_slip), 64'd0);
    sok = 1'b1;
    step(1'b0, 2'b00);
    good_run(3);
    step(1'b1, 2'b11);
    step(1'b1, 2'($urandom_range(0, 3)));
    sok = 1'b0;
    step(1'b1, 2'($urandom_range(0, 3)));
    sok = 1'b1;
    step(1'b0, 2'b00);
    chk("s5_slip_count", 64'(n_slip), 64'd1);
    good_run(WIN - 1);
    chk("s5_pre_lock", 64'(lock), 64'd0);
    good_run(1);
    chk("s5_relock", 64'(lock), 64'd1);

    // 6: asynchronous reset mid-window while locked
    good_run(30);
    vin = 1'b1;
    hin = good_hdr();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    step(1'b0, 2'b00);
    reset = 1'b0;
    step(1'b0, 2'b00);
    good_run(WIN - 1);
    chk("s6_pre_lock", 64'(lock), 64'd0);
    good_run(1);
    chk("s6_relock", 64'(lock), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
